// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - ALU/load/memory/register-write bundle for the writeback stage
interface reg_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_ready;

  logic        load_req;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic        load_ready;

  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        reg_write_control;
  logic [4:0]  reg_write_select;
  logic [31:0] reg_write_data;

  logic        busy;
  logic [4:0]  busy_rd;
  logic        load_err;

  modport master (
    output alu_valid, alu_rd, alu_result, load_req, load_rd, load_funct3, load_addr_lo,
           mem_rvalid, mem_rdata,
    input  alu_ready, load_ready, reg_write_control, reg_write_select, reg_write_data,
           busy, busy_rd, load_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, load_req, load_rd, load_funct3, load_addr_lo,
           mem_rvalid, mem_rdata,
    output alu_ready, load_ready, reg_write_control, reg_write_select, reg_write_data,
           busy, busy_rd, load_err
  );
endinterface

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - writeback arbiter: one outstanding load, one-entry ALU buffer
module reg_writeback (
  input logic            clk,
  input logic            reset,
  reg_writeback_if.slave bus
);

  typedef enum logic {IDLE, WAIT_MEM} state_e;

  state_e      state_q, state_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;

  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;

  logic        wr_ctrl_q, wr_ctrl_d;
  logic [4:0]  wr_sel_q, wr_sel_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        err_q, err_d;

  logic        alu_accept, load_accept, load_resp;
  logic        sel_valid, sel_err;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic [31:0] ld_data;
  logic        ld_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign bus.alu_ready         = !buf_valid_q;
  assign bus.load_ready        = (state_q == IDLE);
  assign bus.busy              = (state_q == WAIT_MEM);
  assign bus.busy_rd           = (state_q == WAIT_MEM) ? ld_rd_q : 5'd0;
  assign bus.reg_write_control = wr_ctrl_q;
  assign bus.reg_write_select  = wr_sel_q;
  assign bus.reg_write_data    = wr_data_q;
  assign bus.load_err          = err_q;

  assign alu_accept  = bus.alu_valid && !buf_valid_q;
  assign load_accept = bus.load_req && (state_q == IDLE);
  assign load_resp   = bus.mem_rvalid && (state_q == WAIT_MEM);

  // Little-endian lane select from the captured low address bits.
  always_comb begin
    byte_sel = 8'h00;
    case (ld_lo_q)
      2'd0: byte_sel = bus.mem_rdata[7:0];
      2'd1: byte_sel = bus.mem_rdata[15:8];
      2'd2: byte_sel = bus.mem_rdata[23:16];
      2'd3: byte_sel = bus.mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = ld_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
  end

  always_comb begin
    ld_data = 32'd0;
    ld_bad  = 1'b0;
    case (ld_f3_q)
      3'b000: ld_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: ld_data = {24'd0, byte_sel};
      3'b001: ld_data = {{16{half_sel[15]}}, half_sel};
      3'b101: ld_data = {16'd0, half_sel};
      3'b010: ld_data = bus.mem_rdata;
      default: begin
        ld_data = 32'd0;
        ld_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    ld_rd_d = ld_rd_q;
    ld_f3_d = ld_f3_q;
    ld_lo_d = ld_lo_q;
    case (state_q)
      IDLE: begin
        if (load_accept) begin
          ld_rd_d = bus.load_rd;
          ld_f3_d = bus.load_funct3;
          ld_lo_d = bus.load_addr_lo;
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load response beats the buffer, which beats a fresh ALU result; a fresh
  // result can only arrive with the buffer empty, so it parks there on a loss.
  always_comb begin
    sel_valid   = 1'b0;
    sel_rd      = 5'd0;
    sel_data    = 32'd0;
    sel_err     = 1'b0;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (load_resp) begin
      sel_valid = 1'b1;
      sel_rd    = ld_rd_q;
      sel_data  = ld_data;
      sel_err   = ld_bad;
      if (alu_accept) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = bus.alu_rd;
        buf_data_d  = bus.alu_result;
      end
    end else if (buf_valid_q) begin
      sel_valid   = 1'b1;
      sel_rd      = buf_rd_q;
      sel_data    = buf_data_q;
      buf_valid_d = 1'b0;
    end else if (alu_accept) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_result;
    end
    wr_ctrl_d = sel_valid && (sel_rd != 5'd0);
    wr_sel_d  = sel_valid ? sel_rd : wr_sel_q;
    wr_data_d = sel_valid ? sel_data : wr_data_q;
    err_d     = sel_err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ld_rd_q     <= 5'd0;
      ld_f3_q     <= 3'd0;
      ld_lo_q     <= 2'd0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= 5'd0;
      buf_data_q  <= 32'd0;
      wr_ctrl_q   <= 1'b0;
      wr_sel_q    <= 5'd0;
      wr_data_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_rd_q     <= ld_rd_d;
      ld_f3_q     <= ld_f3_d;
      ld_lo_q     <= ld_lo_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      wr_ctrl_q   <= wr_ctrl_d;
      wr_sel_q    <= wr_sel_d;
      wr_data_q   <= wr_data_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - scoreboard bench for reg_writeback
module tb_reg_writeback;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_writeback_if bus ();

  reg_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wr_t;

  wr_t sb_q[$];
  wr_t exp_wr;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = d >> (8 * lo);
    b  = sh[7:0];
    sh = lo[1] ? (d >> 16) : d;
    h  = sh[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      3'b010:  return d;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.reg_write_control) begin
        if (sb_q.size() == 0) begin
          check("unexpected_wr", 32'(bus.reg_write_control), 32'd0);
        end else begin
          exp_wr = sb_q.pop_front();
          check("wr_rd", 32'(bus.reg_write_select), 32'(exp_wr.rd));
          check("wr_data", bus.reg_write_data, exp_wr.data);
          check("wr_err", 32'(bus.load_err), 32'(exp_wr.err));
        end
      end else if (bus.load_err) begin
        check("stray_err", 32'(bus.load_err), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_send(input logic [4:0] rd, input logic [31:0] data);
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = rd;
    bus.alu_result = data;
    if (rd != 5'd0) sb_q.push_back({rd, data, 1'b0});
    tick();
    bus.alu_valid = 1'b0;
  endtask

  task automatic load_issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    bus.load_req     = 1'b1;
    bus.load_rd      = rd;
    bus.load_funct3  = f3;
    bus.load_addr_lo = lo;
    tick();
    bus.load_req = 1'b0;
  endtask

  task automatic load_txn(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                          input logic [31:0] mdata, input logic [31:0] exp_data,
                          input logic err);
    load_issue(rd, f3, lo);
    check("busy_set", 32'(bus.busy), 32'd1);
    check("busy_rd", 32'(bus.busy_rd), 32'(rd));
    check("load_ready_lo", 32'(bus.load_ready), 32'd0);
    tick();
    check("busy_hold", 32'(bus.busy), 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = mdata;
    if (rd != 5'd0) sb_q.push_back({rd, exp_data, err});
    tick();
    bus.mem_rvalid = 1'b0;
    check("busy_clr", 32'(bus.busy), 32'd0);
    check("load_ready_hi", 32'(bus.load_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] f3_tab [5];
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] d;
    logic [4:0]  rd;
    f3_tab = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};

    reset            = 1'b1;
    bus.alu_valid    = 1'b0;
    bus.alu_rd       = 5'd0;
    bus.alu_result   = 32'd0;
    bus.load_req     = 1'b0;
    bus.load_rd      = 5'd0;
    bus.load_funct3  = 3'd0;
    bus.load_addr_lo = 2'd0;
    bus.mem_rvalid   = 1'b0;
    bus.mem_rdata    = 32'd0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_ctrl", 32'(bus.reg_write_control), 32'd0);
    check("rst_sel", 32'(bus.reg_write_select), 32'd0);
    check("rst_data", bus.reg_write_data, 32'd0);
    check("rst_err", 32'(bus.load_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_busy_rd", 32'(bus.busy_rd), 32'd0);
    check("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst_load_ready", 32'(bus.load_ready), 32'd1);
    mon_en = 1'b1;

    // ALU path latency, then hold with no source
    alu_send(5'd5, 32'h1234_5678);
    @(negedge clk);
    check("alu_lat_ctrl", 32'(bus.reg_write_control), 32'd1);
    check("alu_lat_sel", 32'(bus.reg_write_select), 32'd5);
    check("alu_lat_data", bus.reg_write_data, 32'h1234_5678);
    tick();
    @(negedge clk);
    check("idle_ctrl", 32'(bus.reg_write_control), 32'd0);
    check("idle_sel_hold", 32'(bus.reg_write_select), 32'd5);
    check("idle_data_hold", bus.reg_write_data, 32'h1234_5678);
    tick();

    // load extraction examples
    load_txn(5'd3, 3'b000, 2'd3, 32'h80FF_0011, 32'hFFFF_FF80, 1'b0);
    load_txn(5'd4, 3'b101, 2'd2, 32'h80FF_0011, 32'h0000_80FF, 1'b0);
    load_txn(5'd6, 3'b010, 2'd1, 32'h80FF_0011, 32'h80FF_0011, 1'b0);
    load_txn(5'd11, 3'b001, 2'd3, 32'h1234_8000, 32'h0000_1234, 1'b0);
    load_txn(5'd12, 3'b100, 2'd1, 32'h0000_9A00, 32'h0000_009A, 1'b0);

    // collision: load response and ALU result in the same cycle
    load_issue(5'd7, 3'b010, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAAAA_0000;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd8;
    bus.alu_result = 32'h0000_0055;
    sb_q.push_back({5'd7, 32'hAAAA_0000, 1'b0});
    sb_q.push_back({5'd8, 32'h0000_0055, 1'b0});
    tick();
    bus.mem_rvalid = 1'b0;
    bus.alu_valid  = 1'b0;
    check("coll_ready_lo", 32'(bus.alu_ready), 32'd0);
    tick();
    check("coll_ready_hi", 32'(bus.alu_ready), 32'd1);
    tick();

    // rd 0: consumed without a write
    alu_send(5'd0, 32'hDEAD_BEEF);
    check("rd0_alu_ready", 32'(bus.alu_ready), 32'd1);
    @(negedge clk);
    check("rd0_alu_ctrl", 32'(bus.reg_write_control), 32'd0);
    load_txn(5'd0, 3'b010, 2'd0, 32'hCAFE_F00D, 32'd0, 1'b0);

    // invalid funct3 values
    load_txn(5'd9, 3'b011, 2'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
    load_txn(5'd13, 3'b111, 2'd2, 32'h1111_2222, 32'd0, 1'b1);

    // reset while waiting for memory abandons the load
    load_issue(5'd10, 3'b010, 2'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_load_ready", 32'(bus.load_ready), 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_1234;
    tick();
    bus.mem_rvalid = 1'b0;
    check("rstw_busy_after", 32'(bus.busy), 32'd0);
    tick();

    // reset with the ALU buffer full discards the buffered result
    load_issue(5'd14, 3'b010, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_0000;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd15;
    bus.alu_result = 32'h0000_00AA;
    sb_q.push_back({5'd14, 32'h7777_0000, 1'b0});
    tick();
    bus.mem_rvalid = 1'b0;
    bus.alu_valid  = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstb_alu_ready", 32'(bus.alu_ready), 32'd1);
    repeat (2) tick();

    // random valid loads interleaved with ALU results
    for (int i = 0; i < 8; i++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      lo = 2'($urandom_range(0, 3));
      d  = $urandom;
      rd = 5'($urandom_range(1, 31));
      load_txn(rd, f3, lo, d, exp_load(f3, lo, d), 1'b0);
      alu_send(5'($urandom_range(1, 31)), $urandom);
    end

    repeat (3) tick();
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports `alu_valid`, `alu_rd`, `alu_result` (inputs; 1, 5, 32 bits): ALU result to retire.
REQ-004 SHALL have port `alu_ready`, output, 1 bit: ALU result accepted when `alu_valid && alu_ready`.
REQ-005 SHALL have ports `load_req`, `load_rd`, `load_funct3`, `load_addr_lo` (inputs; 1, 5, 3, 2 bits): load issue (`load_addr_lo` = address bits [1:0]).
REQ-006 SHALL have port `load_ready`, output, 1 bit: load accepted when `load_req && load_ready`.
REQ-007 SHALL have ports `mem_rvalid`, `mem_rdata` (inputs; 1, 32 bits): memory read response, little-endian word.
REQ-008 SHALL have ports `reg_write_control`, `reg_write_select`, `reg_write_data` (outputs; 1, 5, 32 bits): register-file write port, all registered.
REQ-009 SHALL have ports `busy`, `busy_rd` (outputs; 1, 5 bits): outstanding-load indicator and its destination, for issue-stage hazard stalls.
REQ-010 SHALL have port `load_err`, output, 1 bit: registered pulse flagging an invalid load funct3.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT_MEM.
- IDLE: `load_ready`=1; an accepted load captures rd/funct3/addr_lo and moves to WAIT_MEM.
- WAIT_MEM: `load_ready`=0; `mem_rvalid`=1 returns to IDLE.
REQ-012 SHALL ignore `mem_rvalid` while in IDLE.
REQ-013 SHALL drive `busy`=1 only in WAIT_MEM; `busy_rd` SHALL be the captured rd in WAIT_MEM and 0 otherwise.
REQ-014 SHALL extract load data as follows:
- LB (000): sign-extended byte `mem_rdata[8*addr_lo +: 8]`.
- LBU (100): the same byte, zero-extended.
- LH (001): sign-extended half selected by `addr_lo[1]`; `addr_lo[0]` ignored.
- LHU (101): the same half, zero-extended.
- LW (010): full word; `addr_lo` ignored.
REQ-015 SHALL treat funct3 011/110/111 as a write of 0x00000000 and pulse `load_err` for one cycle, aligned with the write cycle.
REQ-016 SHALL contain a one-entry ALU holding buffer; `alu_ready` SHALL equal NOT(buffer valid), combinationally.
REQ-017 SHALL select write source each cycle by fixed priority:
- 1st: load response (WAIT_MEM && `mem_rvalid`).
- 2nd: buffered ALU result.
- 3rd: newly accepted ALU result.
REQ-018 SHALL place an accepted ALU result into the buffer when a load response wins the same cycle; the buffer SHALL drain on the next cycle with no load response.
REQ-019 SHALL hold a valid buffer unchanged while load responses win.
REQ-020 SHALL register writes with 1-cycle latency: a source selected in cycle N appears on `reg_write_*` in cycle N+1, with `reg_write_control` high for exactly one cycle per retired result.
REQ-021 SHALL force `reg_write_control`=0 when the selected rd is 0; the result is still consumed (buffer freed / FSM to IDLE).
REQ-022 SHALL drive `reg_write_control`=0 in any cycle with no selected source; `reg_write_select`/`reg_write_data` SHALL then hold their previous values.
REQ-023 SHALL NOT reorder writes to the same rd relative to arrival order; program-order hazards are resolved upstream using `busy`/`busy_rd`.

Reset
REQ-024 SHALL on `reset`=1 at a rising edge:
- Set FSM to IDLE and clear the buffer.
- Set `reg_write_control`, `reg_write_select`, `reg_write_data`, `load_err` to 0.
- Set `busy`=0 and `busy_rd`=0.
REQ-025 SHALL, when reset occurs in WAIT_MEM, abandon the pending load; a later `mem_rvalid` SHALL produce no write.
REQ-026 SHALL, when reset occurs with a valid buffer, discard it without writing.

Verification
REQ-027 ALU path: `alu_valid`=1, rd=5, result=0x12345678 at cycle 0 -> cycle 1: `reg_write_control`=1, select=5, data=0x12345678.
REQ-028 Load extract: LB, addr_lo=3, mem_rdata=0x80FF0011 -> data 0xFFFFFF80; LHU, addr_lo=2 -> 0x000080FF; LW -> 0x80FF0011; `busy`=1 with `busy_rd`=load rd until response.
REQ-029 Collision: `mem_rvalid` (LW, rd=7, data=0xAAAA0000) and `alu_valid` (rd=8, 0x55) in the same cycle:
- Next cycle: write rd=7, data 0xAAAA0000.
- Cycle after: write rd=8, data 0x55.
- `alu_ready`=0 for exactly one cycle.
REQ-030 rd=0: ALU result 0xDEADBEEF to rd 0 -> no write pulse, `alu_ready` stays 1; LW to rd 0 -> FSM returns to IDLE with no write.
REQ-031 Invalid load and reset: funct3=011 -> write 0x00000000 plus one-cycle `load_err`; separately, reset in WAIT_MEM then `mem_rvalid` -> no write, `busy`=0.
